alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU control decoder: it accepts an (x_ALU, fn_code) pair over a valid/ready interface and returns the ALU control word one cycle later. Adds a multi-cycle multiply operation with a busy window, illegal-code detection, and parametrised field widths. It sits between the main control unit/ID stage and the ALU datapath.

## Interface
- FN_W, 6, function-code width; must be ≥4.
- OP_W, 3, x_ALU width; must be ≥2.
- CTRL_W, 4, control-word width; must be ≥4; bits above [3:0] always 0.
- MUL_CYCLES, 8, multiply busy length in cycles; must be ≥2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- x_ALU  in  OP_W  operation class.
- fn_code  in  FN_W  function code (used when x_ALU==1).
- out_valid  out  1  control word complete.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- control  out  CTRL_W  ALU control word.
- busy  out  1  multiply in progress.
- illegal  out  1  sticky illegal-code flag.

## Operation
- Decode (inputs zero-extended before comparison): x_ALU 0 -> 0111; 1 -> fn_code table; 2 -> 0001; 3 -> 0010; any other x_ALU -> illegal.
- fn_code table: 1->0001, 2->0010, 3->0011, 4->0100, 5->0000, 6->1110, 7->1101, 8->0110, 9->0101, 10->1111, 11->0111, 12->1000 (multiply, multi-cycle); any other value -> illegal.
- Illegal requests decode to 1100 (NOP) and complete as single-cycle ops.
- States: IDLE, BUSY, VALID.
- IDLE: in_ready=1. Accepted single-cycle op -> VALID, control loaded. Accepted multiply -> BUSY, control=1000, counter=MUL_CYCLES-1.
- BUSY: in_ready=0, busy=1, control=1000. Counter decrements each cycle. At counter==0 -> VALID next cycle.
- VALID: out_valid=1, control held. in_ready = out_ready.
  - out_ready=0: stay in VALID.
  - out_ready=1, no new request: -> IDLE.
  - out_ready=1 with in_valid: new request accepted in the same cycle and follows the IDLE transition rules. This gives back-to-back throughput.
- In IDLE, control holds its last value. out_valid and busy are 0 outside VALID and BUSY respectively.
- Counter width is $clog2(MUL_CYCLES). It never wraps: it is only loaded on entry to BUSY.

## Timing
- Reset values: state IDLE, control 0, out_valid 0, busy 0, illegal 0, counter 0, in_ready 0 during the rst cycle.
- Single-cycle op: accepted at edge N -> out_valid and control valid after edge N.
- Multiply: accepted at edge N -> busy high for exactly MUL_CYCLES cycles -> out_valid rises the cycle after busy falls. Latency is MUL_CYCLES+1.
- Inputs are sampled only on the accepting edge. Changes while in BUSY or a stalled VALID are ignored.
- rst mid-BUSY or mid-VALID: next cycle matches the reset values. The pending result is dropped and no out_valid is issued.
- rst has priority over a simultaneous accept.

## Configuration
- ALU_CTRL_ILLEGAL_TRAP_EN defined:
  - An accepted illegal request sets illegal on the following edge.
  - illegal remains 1 until rst.
  - Legal requests never clear it.
- Undefined: illegal is constant 0. Illegal codes still decode to 1100 with normal handshake.

## Test plan
- Reset with in_valid=1, x_ALU=0 -> during rst: in_ready=0, out_valid=0, control=0; first accept after release -> control=0111 next cycle.
- Stream x_ALU=1, fn_code=1..11 with out_ready=1 -> one result per cycle; controls 0001,0010,0011,0100,0000,1110,1101,0110,0101,1111,0111 in order.
- x_ALU=1, fn_code=12, MUL_CYCLES=8 -> busy high 8 cycles with control=1000; out_valid at cycle 9; in_ready=0 throughout busy.
- out_ready=0 for 3 cycles after x_ALU=2 -> out_valid and control=0001 held; in_ready=0; a new x_ALU=3 accepted on the out_ready=1 edge -> control=0010 next cycle.
- With the macro: x_ALU=5, then fn_code=0 -> control=1100; illegal=1 from the next edge, stays 1 through later legal ops until rst. Without the macro, illegal stays 0.
- rst asserted at busy cycle 4 of a multiply -> busy=0, out_valid=0 next cycle; no result is ever issued.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Request/result handshake bundle between the control unit and alu_ctrl_seq.
// master = requester/consumer side, slave = the sequencer itself.
interface alu_ctrl_seq_if #(
   parameter int FN_W   = 6,
   parameter int OP_W   = 3,
   parameter int CTRL_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   x_ALU;
   logic [FN_W-1:0]   fn_code;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] control;
   logic              busy;
   logic              illegal;

   modport master (
      output in_valid, x_ALU, fn_code, out_ready,
      input  in_ready, out_valid, control, busy, illegal
   );

   modport slave (
      input  in_valid, x_ALU, fn_code, out_ready,
      output in_ready, out_valid, control, busy, illegal
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder with a multi-cycle multiply window.
// Optional sticky illegal-code trap: define ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_seq #(
   parameter int FN_W       = 6,
   parameter int OP_W       = 3,
   parameter int CTRL_W     = 4,
   parameter int MUL_CYCLES = 8
) (
   input logic           clk,
   input logic           rst,
   alu_ctrl_seq_if.slave bus
);
   localparam int CNT_W = $clog2(MUL_CYCLES);

   localparam logic [3:0] CTRL_MUL = 4'b1000;
   localparam logic [3:0] CTRL_NOP = 4'b1100;

   typedef enum logic [1:0] {IDLE, BUSY, VALID} state_e;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       is_mul;
      logic       is_illegal;
   } dec_t;

   function automatic dec_t decode(input logic [OP_W-1:0] op, input logic [FN_W-1:0] fn);
      dec_t d;
      d.ctrl       = CTRL_NOP;
      d.is_mul     = 1'b0;
      d.is_illegal = 1'b0;
      case (op)
         OP_W'(0): d.ctrl = 4'b0111;
         OP_W'(1): begin
            case (fn)
               FN_W'(1):  d.ctrl = 4'b0001;
               FN_W'(2):  d.ctrl = 4'b0010;
               FN_W'(3):  d.ctrl = 4'b0011;
               FN_W'(4):  d.ctrl = 4'b0100;
               FN_W'(5):  d.ctrl = 4'b0000;
               FN_W'(6):  d.ctrl = 4'b1110;
               FN_W'(7):  d.ctrl = 4'b1101;
               FN_W'(8):  d.ctrl = 4'b0110;
               FN_W'(9):  d.ctrl = 4'b0101;
               FN_W'(10): d.ctrl = 4'b1111;
               FN_W'(11): d.ctrl = 4'b0111;
               FN_W'(12): begin
                  d.ctrl   = CTRL_MUL;
                  d.is_mul = 1'b1;
               end
               default:   d.is_illegal = 1'b1;
            endcase
         end
         OP_W'(2): d.ctrl = 4'b0001;
         OP_W'(3): d.ctrl = 4'b0010;
         default:  d.is_illegal = 1'b1;
      endcase
      return d;
   endfunction

   state_e           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready, out_valid, busy, accept;
   dec_t             dec;

   assign dec = decode(bus.x_ALU, bus.fn_code);

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned; that is what keeps this block latch-free.
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: in_ready = !rst;
         BUSY: begin
            busy = 1'b1;
            if (cnt_q == '0) state_d = VALID;
            else             cnt_d   = cnt_q - 1'b1;
         end
         VALID: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready && !rst;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An accept overrides the hand-back to IDLE, giving back-to-back results.
      accept = bus.in_valid && in_ready;
      if (accept) begin
         ctrl_d = dec.ctrl;
         if (dec.is_mul) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
         end else begin
            state_d = VALID;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk) begin
      if (rst)                          illegal_q <= 1'b0;
      else if (accept && dec.is_illegal) illegal_q <= 1'b1;
   end

   assign bus.illegal = illegal_q;
`else
   logic unused_illegal;
   assign unused_illegal = dec.is_illegal;
   assign bus.illegal    = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.control   = CTRL_W'(ctrl_q);
endmodule
